// File: rtl/timer_pkg.sv
// Shared constants and types for the memory-mapped timer peripheral.
// Offsets are word indices, matching Address[4:2].
package timer_pkg;

  localparam logic [2:0] TH_OFS      = 3'd0;
  localparam logic [2:0] TL_OFS      = 3'd1;
  localparam logic [2:0] TCON_OFS    = 3'd2;
  localparam logic [2:0] SYSTICK_OFS = 3'd5;

  localparam int EN_BIT      = 0;
  localparam int IE_BIT      = 1;
  localparam int IF_BIT      = 2;
  localparam int ONESHOT_BIT = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/mmio_timer_periph_if.sv
// MEM-stage load/store bus between the CPU (master) and a peripheral (slave).
interface mmio_timer_periph_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport master (
    output MemRead,
    output MemWrite,
    output Address,
    output Write_data,
    input  Read_data
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  Address,
    input  Write_data,
    output Read_data
  );

endinterface

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE while run is high; tick marks the last count.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE) + 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  // Stopping the timer parks the count at 0 so a restart always waits a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer_periph.sv
// Memory-mapped reloadable timer with prescaler, one-shot mode and level irq.
// Optional free-running SYSTICK counter at offset 0x14 when TIMER_SYSTICK_EN is defined.
module mmio_timer_periph
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  mmio_timer_periph_if.slave         bus,
  output logic                       irq
);

  state_t      r_state;
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_ie;
  logic        r_if;
  logic        r_oneshot;
  logic        r_irq;

  logic        w_hit;
  logic [2:0]  w_ofs;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_tick;
  logic        w_ovf;
  logic        w_ie_nxt;
  logic        w_if_nxt;
  logic [31:0] w_tcon;
  logic [31:0] w_systick;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_hit     = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign w_ofs     = bus.Address[4:2];
  assign w_unused  = &{1'b0, bus.Address[1:0]};
  assign w_wr_th   = bus.MemWrite && w_hit && (w_ofs == TH_OFS);
  assign w_wr_tl   = bus.MemWrite && w_hit && (w_ofs == TL_OFS);
  assign w_wr_tcon = bus.MemWrite && w_hit && (w_ofs == TCON_OFS);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (r_state == COUNT),
    .tick  (w_tick)
  );

  // A CPU write to TL on the same edge suppresses both the increment and the overflow.
  assign w_ovf = w_tick && (r_tl == 32'hFFFF_FFFF) && !w_wr_tl;

  // Hardware setting IF beats a software write-1-to-clear on the same edge.
  always_comb begin
    w_ie_nxt = w_wr_tcon ? bus.Write_data[IE_BIT] : r_ie;
    w_if_nxt = (r_if && !(w_wr_tcon && bus.Write_data[IF_BIT])) || w_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th <= '0;
      r_tl <= '0;
    end else begin
      if (w_wr_th) begin
        r_th <= bus.Write_data;
      end
      if (w_wr_tl) begin
        r_tl <= bus.Write_data;
      end else if (w_ovf) begin
        r_tl <= r_th;
      end else if (w_tick) begin
        r_tl <= r_tl + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ie      <= 1'b0;
      r_if      <= 1'b0;
      r_oneshot <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_tcon && bus.Write_data[EN_BIT]) begin
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if ((w_wr_tcon && !bus.Write_data[EN_BIT]) || (w_ovf && r_oneshot)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_wr_tcon) begin
        r_oneshot <= bus.Write_data[ONESHOT_BIT];
      end
      r_ie  <= w_ie_nxt;
      r_if  <= w_if_nxt;
      r_irq <= w_ie_nxt && w_if_nxt;
    end
  end

`ifdef TIMER_SYSTICK_EN
  logic [31:0] r_systick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end

  assign w_systick = r_systick;
`else
  assign w_systick = '0;
`endif

  always_comb begin
    w_tcon              = '0;
    w_tcon[EN_BIT]      = (r_state == COUNT);
    w_tcon[IE_BIT]      = r_ie;
    w_tcon[IF_BIT]      = r_if;
    w_tcon[ONESHOT_BIT] = r_oneshot;
  end

  // Reads return pre-write register contents when a store hits the same cycle.
  always_comb begin
    w_rdata = '0;
    if (bus.MemRead && w_hit) begin
      case (w_ofs)
        TH_OFS:      w_rdata = r_th;
        TL_OFS:      w_rdata = r_tl;
        TCON_OFS:    w_rdata = w_tcon;
        SYSTICK_OFS: w_rdata = w_systick;
        default:     w_rdata = '0;
      endcase
    end
  end

  assign bus.Read_data = w_rdata;
  assign irq           = r_irq;

endmodule

// File: tb/tb_mmio_timer_periph.sv
// Directed bench for mmio_timer_periph: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_mmio_timer_periph;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE + 32'h00;
  localparam logic [31:0] A_TL = BASE + 32'h04;
  localparam logic [31:0] A_TC = BASE + 32'h08;
  localparam logic [31:0] A_0C = BASE + 32'h0C;
  localparam logic [31:0] A_ST = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        irq1;
  logic        irq4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mmio_timer_periph_if bus1 ();
  mmio_timer_periph_if bus4 ();

  assign bus1.MemRead    = mem_read;
  assign bus1.MemWrite   = mem_write;
  assign bus1.Address    = addr;
  assign bus1.Write_data = wdata;
  assign bus4.MemRead    = mem_read;
  assign bus4.MemWrite   = mem_write;
  assign bus4.Address    = addr;
  assign bus4.Write_data = wdata;

  mmio_timer_periph #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave),
    .irq   (irq1)
  );

  mmio_timer_periph #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave),
    .irq   (irq4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Store presented at the current negedge, committed on the following posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1 mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d4);
    addr     = a;
    mem_read = 1'b1;
    #1;
    d1       = bus1.Read_data;
    d4       = bus4.Read_data;
    mem_read = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d1, d4;
    rd(a, d1, d4);
    chk(tag, d1, exp);
  endtask

  task automatic chk4(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d1, d4;
    rd(a, d1, d4);
    chk(tag, d4, exp);
  endtask

  initial begin
    logic [31:0] s1, s4, t1, t4;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    reset     = 1'b1;
    step(2);

    // Reset state
    chk1("rst_th", A_TH, 32'h0);
    chk1("rst_tl", A_TL, 32'h0);
    chk1("rst_tcon", A_TC, 32'h0);
    chk("rst_irq1", {31'b0, irq1}, 32'h0);
    chk("rst_irq4", {31'b0, irq4}, 32'h0);
    reset = 1'b0;
    step(1);

    // Overflow and reload, PRESCALE=1
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    chk1("th_wr", A_TH, 32'hFFFF_FFFC);
    wr(A_TC, 32'h3);
    chk1("tl_en_edge", A_TL, 32'hFFFF_FFFE);
    step(1);
    chk1("tl_first_tick", A_TL, 32'hFFFF_FFFF);
    chk1("tcon_pre_ovf", A_TC, 32'h3);
    chk("irq_pre_ovf", {31'b0, irq1}, 32'h0);
    step(1);
    chk1("tl_reload", A_TL, 32'hFFFF_FFFC);
    chk1("tcon_ovf", A_TC, 32'h7);
    chk("irq_ovf", {31'b0, irq1}, 32'h1);
    step(1);
    chk1("tl_after_reload", A_TL, 32'hFFFF_FFFD);

    // Write-1-to-clear, then clear racing an overflow
    wr(A_TC, 32'h7);
    chk1("tcon_w1c", A_TC, 32'h3);
    chk("irq_w1c", {31'b0, irq1}, 32'h0);
    chk1("tl_w1c", A_TL, 32'hFFFF_FFFE);
    step(1);
    chk1("tl_pre_race", A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h7);
    chk1("tcon_race", A_TC, 32'h7);
    chk("irq_race", {31'b0, irq1}, 32'h1);
    chk1("tl_race", A_TL, 32'hFFFF_FFFC);

    // Asynchronous reset while counting with IF pending
    reset = 1'b1;
    #1;
    chk1("midrst_tl", A_TL, 32'h0);
    chk1("midrst_tcon", A_TC, 32'h0);
    chk1("midrst_th", A_TH, 32'h0);
    chk("midrst_irq", {31'b0, irq1}, 32'h0);
    step(1);
    reset = 1'b0;
    step(3);
    chk1("postrst_tcon", A_TC, 32'h0);
    chk1("postrst_tl", A_TL, 32'h0);

    // One-shot: reload then stop
    wr(A_TH, 32'h10);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'hB);
    step(1);
    chk1("os_tl", A_TL, 32'h10);
    chk1("os_tcon", A_TC, 32'hE);
    chk("os_irq", {31'b0, irq1}, 32'h1);
    step(20);
    chk1("os_hold", A_TL, 32'h10);

    // Decode: unmapped offset and out-of-window address
    wr(A_0C, 32'hDEAD_BEEF);
    chk1("ofs_0c", A_0C, 32'h0);
    chk1("miss_addr", 32'h5000_0000, 32'h0);
    chk1("th_unaligned", A_TH + 32'h3, 32'h10);

    // PRESCALE=4 timing and TL write on a tick edge
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    wr(A_TC, 32'h1);
    step(3);
    chk4("p4_n3", A_TL, 32'h0);
    step(1);
    chk4("p4_n4", A_TL, 32'h1);
    step(3);
    chk4("p4_n7", A_TL, 32'h1);
    wr(A_TL, 32'h5);
    chk4("p4_wr_wins", A_TL, 32'h5);
    step(3);
    chk4("p4_n11", A_TL, 32'h5);
    step(1);
    chk4("p4_n12", A_TL, 32'h6);

    // TCON upper bits read 0; clearing EN stops counting
    wr(A_TC, 32'hFFFF_FFF0);
    chk1("tcon_hi", A_TC, 32'h0);
    chk4("tcon_hi4", A_TC, 32'h0);
    rd(A_TL, s1, s4);
    step(8);
    chk4("p4_stopped", A_TL, s4);

`ifdef TIMER_SYSTICK_EN
    rd(A_ST, s1, s4);
    step(100);
    rd(A_ST, t1, t4);
    chk("systick_diff1", t1 - s1, 32'd100);
    chk("systick_diff4", t4 - s4, 32'd100);
`else
    rd(A_ST, s1, s4);
    chk("systick_off1", s1, 32'h0);
    chk("systick_off4", s4, 32'h0);
    t1 = '0;
    t4 = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_timer_periph.md
# mmio_timer_periph

Memory-mapped timer peripheral that responds to the CPU's MEM-stage data bus, the other end of the CPU's load/store interface. It decodes CPU reads and writes within a 32-byte window and provides a reloadable 32-bit timer with a prescaler, one-shot or auto-reload mode, a sticky overflow flag and a level interrupt. Its read data is muxed or ORed with data-memory read data at the CPU top.

## Interface
- BASE_ADDR, 32'h4000_0000: window base, 32-byte aligned.
- PRESCALE, 1: clk cycles per timer tick; legal range 1..65535.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- MemRead  in  1  CPU load strobe (MEM stage).
- MemWrite  in  1  CPU store strobe (MEM stage).
- Address  in  32  byte address (MEM-stage ALU output).
- Write_data  in  32  store data.
- Read_data  out  32  load data, combinational.
- irq  out  1  interrupt, level, active-high.

## Operation
- Hit: Address[31:5]==BASE_ADDR[31:5]. Word offset is Address[4:2]. Address[1:0] is ignored.
- Register map:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: count, R/W.
  - 0x08 TCON: R/W.
  - 0x14 SYSTICK: RO, macro-dependent.
  - All other offsets read 0 and ignore writes.
- TCON bits:
  - [0] EN.
  - [1] IE.
  - [2] IF: sticky, write-1-to-clear.
  - [3] ONESHOT.
  - [31:4] read 0.
- Read_data is the selected register when MemRead and hit, else 32'h0.
- Writes require MemWrite and hit and take effect on the posedge. MemRead and MemWrite asserted together: the write occurs and the read returns the pre-write value.
- FSM has two states:
  - IDLE (EN=0): TL holds and the prescaler is held at 0.
  - COUNT (EN=1).
  - IDLE→COUNT when EN is written to 1. COUNT→IDLE when EN is written to 0, or on overflow while ONESHOT=1 (hardware clears EN).
- Prescaler: in COUNT, counts 0..PRESCALE-1. A tick occurs in the cycle the count equals PRESCALE-1, and the count wraps to 0.
- Tick with TL≠32'hFFFF_FFFF: TL←TL+1.
- Tick with TL=32'hFFFF_FFFF (overflow): TL←TH and IF←1, regardless of IE.
- irq = IE & IF, driven from registers.
- Simultaneous events:
  - CPU write to TL on a tick edge: write wins, no increment, no overflow.
  - CPU write to TH on an overflow edge: reload uses the old TH.
  - CPU write to TCON on an overflow edge: EN/IE/ONESHOT take the written values, except that ONESHOT overflow forces EN=0. Next IF = (IF & ~Write_data[2]) | overflow, so hardware set beats software clear.
- Reset mid-count: all state returns to reset values immediately; no pending tick survives.

## Timing
- Reset values: TH=0, TL=0, TCON=0, prescaler=0, state IDLE, SYSTICK=0, Read_data=0, irq=0.
- Read latency is 0 cycles (combinational, same cycle as MemRead).
- Write latency: the new value is visible to a read in the next cycle.
- EN written at edge N: the first tick is at edge N+PRESCALE.
- Overflow at edge N: IF and irq are high from cycle N+1.
- In COUNT, TL advances exactly once per PRESCALE cycles.

## Configuration
- TIMER_SYSTICK_EN defined: a 32-bit free-running SYSTICK counter increments every clk from reset, wraps at 2^32, is unaffected by EN, and reads at 0x14.
- TIMER_SYSTICK_EN undefined: no counter is built and 0x14 reads 0.

## Structure
- Shared package `timer_pkg`:
  - offset constants TH_OFS, TL_OFS, TCON_OFS, SYSTICK_OFS;
  - TCON bit indices EN_BIT, IE_BIT, IF_BIT, ONESHOT_BIT;
  - state typedef {IDLE, COUNT}.
- One sub-module, `timer_prescaler`: inputs clk, reset, run; output tick; parameter PRESCALE; counter width $clog2(PRESCALE)+1.

## Test plan
- Reset asserted mid-count → all reads 0 and irq=0 in the same cycle; state IDLE after release.
- TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=0x3, PRESCALE=1 → TL reads FFFF_FFFF, then FFFF_FFFC, then FFFF_FFFD. TCON reads 0x7 and irq=1 from the cycle after overflow.
- Write TCON=0x7 with IF set → IF clears and irq drops the next cycle. The same write on an overflow edge → IF stays 1.
- TCON=0xB (one-shot), TL=FFFF_FFFF, TH=0x10 → after the tick TL=0x10, TCON=0xE, and TL holds at 0x10 for 20 further cycles.
- PRESCALE=4, TL=0, EN written at edge N → TL=1 at N+4 and 2 at N+8. A write of TL=5 on edge N+8 → TL=5, then 6 at N+12.
- With TIMER_SYSTICK_EN: two reads of 0x14 taken 100 cycles apart differ by exactly 100. Without it: 0x14 reads 0. Read of 0x0C or of address 0x5000_0000 → 0.
